// File: rtl/abr_1r1w_ram_arb_if.sv
// Requester-side bus of the 1R1W RAM arbiter: per-requester write/read
// requests, their grants and the shared read-response channel.
interface abr_1r1w_ram_arb_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);

  // Write channel, requester k occupies slice k of the packed vectors
  logic [NUM_REQ-1:0]            wr_req_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_i;
  logic [NUM_REQ-1:0]            wr_gnt_o;

  // Read channel
  logic [NUM_REQ-1:0]            rd_req_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_REQ-1:0]            rd_gnt_o;

  // Read response, data shared by all requesters
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;

  // Requester side
  modport master (
    output wr_req_i,
    output wr_addr_i,
    output wr_data_i,
    output rd_req_i,
    output rd_addr_i,
    input  wr_gnt_o,
    input  rd_gnt_o,
    input  rsp_valid_o,
    input  rsp_data_o
  );

  // Arbiter side
  modport slave (
    input  wr_req_i,
    input  wr_addr_i,
    input  wr_data_i,
    input  rd_req_i,
    input  rd_addr_i,
    output wr_gnt_o,
    output rd_gnt_o,
    output rsp_valid_o,
    output rsp_data_o
  );

endinterface

// File: rtl/abr_1r1w_ram_arb.sv
// Round-robin arbiter sharing one 1-read/1-write RAM between NUM_REQ
// requesters. Write and read ports are arbitrated independently, each with
// its own rotating priority pointer. Read responses are returned one cycle
// after the grant, tagged one-hot with the requester that issued the read.
// With FWD_EN set, a same-cycle write/read to the same address returns the
// new write data instead of the pre-write RAM contents.
module abr_1r1w_ram_arb #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_b,
  abr_1r1w_ram_arb_if.slave     req_if,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_waddr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  ram_re_o,
  output logic [ADDR_WIDTH-1:0] ram_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Priority pointers: index of the requester searched first
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;

  // Arbitration results
  logic                  wr_hit, rd_hit;
  ptr_t                  wr_idx, rd_idx;
  logic [NUM_REQ-1:0]    wr_gnt, rd_gnt;

  // Response path
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic                  fwd_hit_d, fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  // Search ptr, ptr+1, ... mod NUM_REQ for the first active request.
  // Returns {found, index}.
  function automatic logic [PTR_W:0] rr_search(input logic [NUM_REQ-1:0] req,
                                               input ptr_t               ptr);
    logic [PTR_W:0] res;
    logic [31:0]    cand;
    res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr) + i) % NUM_REQ;
      if (!res[PTR_W] && req[cand[PTR_W-1:0]]) begin
        res = {1'b1, cand[PTR_W-1:0]};
      end
    end
    return res;
  endfunction

  // Position after the granted requester, wrapping at NUM_REQ-1
  function automatic ptr_t rr_next(input ptr_t idx);
    return (idx == ptr_t'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Independent round-robin search for the write and read ports
  always_comb begin
    {wr_hit, wr_idx} = rr_search(req_if.wr_req_i, wr_ptr_q);
    {rd_hit, rd_idx} = rr_search(req_if.rd_req_i, rd_ptr_q);
  end

  // One-hot grant decode; all-zero when nothing is requested
  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (wr_hit) begin
      wr_gnt[wr_idx] = 1'b1;
    end
    if (rd_hit) begin
      rd_gnt[rd_idx] = 1'b1;
    end
  end

  assign req_if.wr_gnt_o = wr_gnt;
  assign req_if.rd_gnt_o = rd_gnt;

  // RAM port mux from the granted requester; zero when idle. Enables are
  // held off while reset is asserted so no RAM access happens during reset.
  always_comb begin
    ram_we_o    = wr_hit & rst_b;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    ram_re_o    = rd_hit & rst_b;
    ram_raddr_o = '0;
    if (wr_hit) begin
      ram_waddr_o = req_if.wr_addr_i[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wdata_o = req_if.wr_data_i[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    end
    if (rd_hit) begin
      ram_raddr_o = req_if.rd_addr_i[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Pointer next state: move past the winner, hold when idle
  always_comb begin
    wr_ptr_d = wr_hit ? rr_next(wr_idx) : wr_ptr_q;
    rd_ptr_d = rd_hit ? rr_next(rd_idx) : rd_ptr_q;
  end

  // Same-cycle write/read collision; the RAM itself returns pre-write data
  always_comb begin
    fwd_hit_d = FWD_EN && ram_we_o && ram_re_o && (ram_waddr_o == ram_raddr_o);
  end

  // Priority pointer state
  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Response tag and forwarding state, aligned with the RAM read latency
  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      rsp_valid_q <= '0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_gnt;
      fwd_hit_q   <= fwd_hit_d;
      if (fwd_hit_d) begin
        fwd_data_q <= ram_wdata_o;
      end
    end
  end

  assign req_if.rsp_valid_o = rsp_valid_q;
  assign req_if.rsp_data_o  = fwd_hit_q ? fwd_data_q : ram_rdata_i;

  // Structural invariants of the arbiter
  a_wr_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_b)
    $onehot0(wr_gnt));
  a_rd_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_b)
    $onehot0(rd_gnt));
  a_rsp_onehot : assert property (@(posedge clk_i) disable iff (!rst_b)
    $onehot0(rsp_valid_q));
  a_wr_ptr_range : assert property (@(posedge clk_i) disable iff (!rst_b)
    32'(wr_ptr_q) < NUM_REQ);
  a_rd_ptr_range : assert property (@(posedge clk_i) disable iff (!rst_b)
    32'(rd_ptr_q) < NUM_REQ);

endmodule

// File: tb/tb_abr_1r1w_ram_arb.sv
// Bench for abr_1r1w_ram_arb. Two instances run side by side:
//   d=0 : NUM_REQ=2, FWD_EN=1
//   d=1 : NUM_REQ=3, FWD_EN=0
// Each drives a behavioural registered-read RAM. A reference model tracks
// priority pointers, memory contents and the expected response per instance.
module tb_abr_1r1w_ram_arb;

  logic clk_i = 1'b0;
  logic rst_b;

  always #5 clk_i = ~clk_i;

  // Stimulus, indexed [instance][requester]
  logic        wr_req  [2][3];
  logic [5:0]  wr_addr [2][3];
  logic [31:0] wr_data [2][3];
  logic        rd_req  [2][3];
  logic [5:0]  rd_addr [2][3];

  // Observed outputs, widened to 3 requesters
  logic [2:0]  wgnt_o  [2];
  logic [2:0]  rgnt_o  [2];
  logic [2:0]  rsp_v_o [2];
  logic [31:0] rsp_d_o [2];
  logic        we_o    [2];
  logic        re_o    [2];
  logic [5:0]  wa_o    [2];
  logic [5:0]  ra_o    [2];
  logic [31:0] wd_o    [2];
  logic [31:0] rdata   [2];

  abr_1r1w_ram_arb_if #(.NUM_REQ(2), .ADDR_WIDTH(6), .DATA_WIDTH(32)) if_a ();
  abr_1r1w_ram_arb_if #(.NUM_REQ(3), .ADDR_WIDTH(6), .DATA_WIDTH(32)) if_b ();

  assign if_a.wr_req_i  = {wr_req[0][1], wr_req[0][0]};
  assign if_a.wr_addr_i = {wr_addr[0][1], wr_addr[0][0]};
  assign if_a.wr_data_i = {wr_data[0][1], wr_data[0][0]};
  assign if_a.rd_req_i  = {rd_req[0][1], rd_req[0][0]};
  assign if_a.rd_addr_i = {rd_addr[0][1], rd_addr[0][0]};

  assign if_b.wr_req_i  = {wr_req[1][2], wr_req[1][1], wr_req[1][0]};
  assign if_b.wr_addr_i = {wr_addr[1][2], wr_addr[1][1], wr_addr[1][0]};
  assign if_b.wr_data_i = {wr_data[1][2], wr_data[1][1], wr_data[1][0]};
  assign if_b.rd_req_i  = {rd_req[1][2], rd_req[1][1], rd_req[1][0]};
  assign if_b.rd_addr_i = {rd_addr[1][2], rd_addr[1][1], rd_addr[1][0]};

  assign wgnt_o[0]  = {1'b0, if_a.wr_gnt_o};
  assign rgnt_o[0]  = {1'b0, if_a.rd_gnt_o};
  assign rsp_v_o[0] = {1'b0, if_a.rsp_valid_o};
  assign rsp_d_o[0] = if_a.rsp_data_o;
  assign wgnt_o[1]  = if_b.wr_gnt_o;
  assign rgnt_o[1]  = if_b.rd_gnt_o;
  assign rsp_v_o[1] = if_b.rsp_valid_o;
  assign rsp_d_o[1] = if_b.rsp_data_o;

  abr_1r1w_ram_arb #(
    .NUM_REQ(2), .DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(6), .FWD_EN(1'b1)
  ) dut_a (
    .clk_i       (clk_i),
    .rst_b       (rst_b),
    .req_if      (if_a.slave),
    .ram_we_o    (we_o[0]),
    .ram_waddr_o (wa_o[0]),
    .ram_wdata_o (wd_o[0]),
    .ram_re_o    (re_o[0]),
    .ram_raddr_o (ra_o[0]),
    .ram_rdata_i (rdata[0])
  );

  abr_1r1w_ram_arb #(
    .NUM_REQ(3), .DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(6), .FWD_EN(1'b0)
  ) dut_b (
    .clk_i       (clk_i),
    .rst_b       (rst_b),
    .req_if      (if_b.slave),
    .ram_we_o    (we_o[1]),
    .ram_waddr_o (wa_o[1]),
    .ram_wdata_o (wd_o[1]),
    .ram_re_o    (re_o[1]),
    .ram_raddr_o (ra_o[1]),
    .ram_rdata_i (rdata[1])
  );

  // Behavioural RAMs: registered read returning pre-write contents
  logic [31:0] ram_a [64] = '{default: '0};
  logic [31:0] ram_b [64] = '{default: '0};

  always @(posedge clk_i) begin
    if (we_o[0]) ram_a[wa_o[0]] <= wd_o[0];
    if (re_o[0]) rdata[0] <= ram_a[ra_o[0]];
    if (we_o[1]) ram_b[wa_o[1]] <= wd_o[1];
    if (re_o[1]) rdata[1] <= ram_b[ra_o[1]];
  end

  // Reference model state
  int          wptr  [2];
  int          rptr  [2];
  int          exp_v [2];
  logic [31:0] exp_d [2];
  logic [31:0] mem_m [2][64];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are set just after a negedge. Check against the
  // model, advance the model, let the edge pass, then drop granted requests.
  task automatic tick();
    int         n, k;
    int         wk [2];
    int         rk [2];
    logic [2:0] ew, er, ev;
    #2;
    for (int d = 0; d < 2; d++) begin
      n     = (d == 0) ? 2 : 3;
      wk[d] = -1;
      rk[d] = -1;
      if (!rst_b) begin
        chk($sformatf("d%0d_rst_we", d), 32'(we_o[d]), 32'd0);
        chk($sformatf("d%0d_rst_re", d), 32'(re_o[d]), 32'd0);
        chk($sformatf("d%0d_rst_rsp_valid", d), 32'(rsp_v_o[d]), 32'd0);
        wptr[d]  = 0;
        rptr[d]  = 0;
        exp_v[d] = -1;
        continue;
      end
      for (int i = 0; i < n; i++) begin
        k = (wptr[d] + i) % n;
        if (wk[d] < 0 && wr_req[d][k]) wk[d] = k;
        k = (rptr[d] + i) % n;
        if (rk[d] < 0 && rd_req[d][k]) rk[d] = k;
      end
      ew = (wk[d] >= 0) ? 3'(1 << wk[d]) : 3'd0;
      er = (rk[d] >= 0) ? 3'(1 << rk[d]) : 3'd0;
      ev = (exp_v[d] >= 0) ? 3'(1 << exp_v[d]) : 3'd0;
      chk($sformatf("d%0d_wr_gnt", d), 32'(wgnt_o[d]), 32'(ew));
      chk($sformatf("d%0d_rd_gnt", d), 32'(rgnt_o[d]), 32'(er));
      chk($sformatf("d%0d_ram_we", d), 32'(we_o[d]), 32'(wk[d] >= 0));
      chk($sformatf("d%0d_ram_re", d), 32'(re_o[d]), 32'(rk[d] >= 0));
      chk($sformatf("d%0d_ram_waddr", d), 32'(wa_o[d]),
          (wk[d] >= 0) ? 32'(wr_addr[d][wk[d]]) : 32'd0);
      chk($sformatf("d%0d_ram_wdata", d), wd_o[d],
          (wk[d] >= 0) ? wr_data[d][wk[d]] : 32'd0);
      chk($sformatf("d%0d_ram_raddr", d), 32'(ra_o[d]),
          (rk[d] >= 0) ? 32'(rd_addr[d][rk[d]]) : 32'd0);
      chk($sformatf("d%0d_rsp_valid", d), 32'(rsp_v_o[d]), 32'(ev));
      if (exp_v[d] >= 0) begin
        chk($sformatf("d%0d_rsp_data", d), rsp_d_o[d], exp_d[d]);
      end
      // Advance the model by this cycle's accepted transactions
      if (rk[d] >= 0) begin
        exp_v[d] = rk[d];
        if (d == 0 && wk[d] >= 0 && wr_addr[d][wk[d]] == rd_addr[d][rk[d]]) begin
          exp_d[d] = wr_data[d][wk[d]];
        end else begin
          exp_d[d] = mem_m[d][rd_addr[d][rk[d]]];
        end
        rptr[d] = (rk[d] + 1) % n;
      end else begin
        exp_v[d] = -1;
      end
      if (wk[d] >= 0) begin
        mem_m[d][wr_addr[d][wk[d]]] = wr_data[d][wk[d]];
        wptr[d] = (wk[d] + 1) % n;
      end
    end
    @(posedge clk_i);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (wk[d] >= 0) wr_req[d][wk[d]] = 1'b0;
      if (rk[d] >= 0) rd_req[d][rk[d]] = 1'b0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    logic [2:0] seq_v;

    for (int d = 0; d < 2; d++) begin
      wptr[d]  = 0;
      rptr[d]  = 0;
      exp_v[d] = -1;
      exp_d[d] = '0;
      for (int a = 0; a < 64; a++) mem_m[d][a] = '0;
      for (int k = 0; k < 3; k++) begin
        wr_req[d][k]  = 1'b0;
        wr_addr[d][k] = '0;
        wr_data[d][k] = '0;
        rd_req[d][k]  = 1'b0;
        rd_addr[d][k] = '0;
      end
    end
    rst_b = 1'b1;
    #1 rst_b = 1'b0;

    // Reset state
    @(negedge clk_i);
    tick();
    tick();
    rst_b = 1'b1;
    tick();

    // Requester 0 writes addr 5, requester 1 reads it back next cycle
    wr_req[0][0] = 1'b1; wr_addr[0][0] = 6'd5; wr_data[0][0] = 32'hA5A5_0001;
    tick();
    rd_req[0][1] = 1'b1; rd_addr[0][1] = 6'd5;
    #1 chk("t1_rd_gnt", 32'(rgnt_o[0]), 32'b10);
    tick();
    chk("t1_rsp_valid", 32'(rsp_v_o[0]), 32'b10);
    chk("t1_rsp_data", rsp_d_o[0], 32'hA5A5_0001);
    tick();

    // Both requesters reading continuously alternate 01,10,01,10
    for (int i = 0; i < 4; i++) begin
      seq_v = (i % 2 == 0) ? 3'b001 : 3'b010;
      rd_req[0][0] = 1'b1; rd_addr[0][0] = 6'd5;
      rd_req[0][1] = 1'b1; rd_addr[0][1] = 6'd6;
      #1 chk($sformatf("t2_rd_gnt_%0d", i), 32'(rgnt_o[0]), 32'(seq_v));
      tick();
      chk($sformatf("t2_rsp_valid_%0d", i), 32'(rsp_v_o[0]), 32'(seq_v));
    end
    rd_req[0][0] = 1'b0;
    rd_req[0][1] = 1'b0;
    tick();

    // Three requesters, only 0 and 2 writing: wrap-around and skip of idle
    for (int i = 0; i < 3; i++) begin
      seq_v = (i == 1) ? 3'b100 : 3'b001;
      wr_req[1][0] = 1'b1; wr_addr[1][0] = 6'd1; wr_data[1][0] = 32'h100 + 32'(i);
      wr_req[1][2] = 1'b1; wr_addr[1][2] = 6'd2; wr_data[1][2] = 32'h200;
      #1 chk($sformatf("t3_wr_gnt_%0d", i), 32'(wgnt_o[1]), 32'(seq_v));
      tick();
    end
    wr_req[1][0] = 1'b0;
    wr_req[1][2] = 1'b0;
    tick();

    // Same-cycle write and read of addr 9: forwarded vs. old contents
    for (int d = 0; d < 2; d++) begin
      wr_req[d][0] = 1'b1; wr_addr[d][0] = 6'd9; wr_data[d][0] = 32'h1234;
      rd_req[d][1] = 1'b1; rd_addr[d][1] = 6'd9;
    end
    tick();
    chk("t4_fwd_data", rsp_d_o[0], 32'h1234);
    chk("t4_nofwd_data", rsp_d_o[1], 32'h0);
    for (int d = 0; d < 2; d++) begin
      rd_req[d][1] = 1'b1; rd_addr[d][1] = 6'd9;
    end
    tick();
    chk("t4_fwd_followup", rsp_d_o[0], 32'h1234);
    chk("t4_nofwd_followup", rsp_d_o[1], 32'h1234);
    tick();

    // Read granted, then reset pulsed in the following cycle
    rd_req[0][0] = 1'b1; rd_addr[0][0] = 6'd5;
    #1 chk("t5_rd_gnt", 32'(rgnt_o[0]), 32'b01);
    @(posedge clk_i);
    rst_b = 1'b0;
    rd_req[0][0] = 1'b0;
    #1 chk("t5_rsp_dropped", 32'(rsp_v_o[0]), 32'd0);
    @(negedge clk_i);
    tick();
    rst_b = 1'b1;
    tick();
    rd_req[0][0] = 1'b1; rd_addr[0][0] = 6'd5;
    rd_req[0][1] = 1'b1; rd_addr[0][1] = 6'd9;
    #1 chk("t5_first_gnt", 32'(rgnt_o[0]), 32'b01);
    tick();

    // Randomized traffic, requests held until granted
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < ((d == 0) ? 2 : 3); k++) begin
          if (!wr_req[d][k] && $urandom_range(0, 2) != 0) begin
            wr_req[d][k]  = 1'b1;
            wr_addr[d][k] = 6'($urandom_range(0, 7));
            wr_data[d][k] = $urandom;
          end
          if (!rd_req[d][k] && $urandom_range(0, 2) != 0) begin
            rd_req[d][k]  = 1'b1;
            rd_addr[d][k] = 6'($urandom_range(0, 7));
          end
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        wr_req[d][k] = 1'b0;
        rd_req[d][k] = 1'b0;
      end
    end
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
